// File: rtl/seq_alu_hs.sv
// seq_alu_hs: clocked ALU with a valid/ready operand handshake.
// Modes 0-6 complete in one cycle. Mode 7 is an iterative shift-add
// multiply that takes WIDTH cycles. Each result is flagged by a
// one-cycle out_valid pulse.
module seq_alu_hs #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           MODE,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   OUT
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned RES_W = 2 * WIDTH;

    localparam logic [2:0] MODE_ADD = 3'd0;
    localparam logic [2:0] MODE_AND = 3'd1;
    localparam logic [2:0] MODE_GT  = 3'd2;
    localparam logic [2:0] MODE_SHR = 3'd3;
    localparam logic [2:0] MODE_SUB = 3'd4;
    localparam logic [2:0] MODE_OR  = 3'd5;
    localparam logic [2:0] MODE_XOR = 3'd6;
    localparam logic [2:0] MODE_MUL = 3'd7;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [RES_W-1:0]   r_out;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [RES_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;

    state_t             w_state_nxt;
    logic               w_in_ready_nxt;
    logic               w_out_valid_nxt;
    logic [RES_W-1:0]   w_out_nxt;
    logic [WIDTH-1:0]   w_a_nxt;
    logic [WIDTH-1:0]   w_b_nxt;
    logic [RES_W-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    logic [RES_W-1:0]   w_a_ext;
    logic [RES_W-1:0]   w_b_ext;
    logic [RES_W-1:0]   w_alu;
    logic [WIDTH-1:0]   w_mb_shr;
    logic [RES_W-1:0]   w_addend;
    logic [RES_W-1:0]   w_acc_sum;
    logic               w_last_step;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign OUT       = r_out;

    assign w_a_ext = RES_W'(A);
    assign w_b_ext = RES_W'(B);

    // Single-cycle operations, all evaluated at full result width
    always_comb begin
        w_alu = '0;
        case (MODE)
            MODE_ADD: w_alu = w_a_ext + w_b_ext;
            MODE_AND: w_alu = w_a_ext & w_b_ext;
            MODE_GT:  w_alu = RES_W'(A > B);
            MODE_SHR: w_alu = w_a_ext >> B;
            MODE_SUB: w_alu = w_a_ext - w_b_ext;
            MODE_OR:  w_alu = w_a_ext | w_b_ext;
            MODE_XOR: w_alu = w_a_ext ^ w_b_ext;
            default:  w_alu = '0;
        endcase
    end

    // One shift-add multiply step: add A<<cnt when multiplier bit cnt is set
    assign w_mb_shr    = r_b >> r_cnt;
    assign w_addend    = w_mb_shr[0] ? (RES_W'(r_a) << r_cnt) : '0;
    assign w_acc_sum   = r_acc + w_addend;
    assign w_last_step = (r_cnt == CNT_W'(WIDTH - 1));

    // Next-state and next-register logic
    always_comb begin
        w_state_nxt     = r_state;
        w_in_ready_nxt  = r_in_ready;
        w_out_valid_nxt = 1'b0;
        w_out_nxt       = r_out;
        w_a_nxt         = r_a;
        w_b_nxt         = r_b;
        w_acc_nxt       = r_acc;
        w_cnt_nxt       = r_cnt;

        case (r_state)
            S_IDLE: begin
                if (in_valid && r_in_ready) begin
                    if (MODE == MODE_MUL) begin
                        w_a_nxt        = A;
                        w_b_nxt        = B;
                        w_acc_nxt      = '0;
                        w_cnt_nxt      = '0;
                        w_in_ready_nxt = 1'b0;
                        w_state_nxt    = S_MUL;
                    end else begin
                        w_out_nxt       = w_alu;
                        w_out_valid_nxt = 1'b1;
                    end
                end
            end
            S_MUL: begin
                w_acc_nxt = w_acc_sum;
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (w_last_step) begin
                    w_out_nxt       = w_acc_sum;
                    w_out_valid_nxt = 1'b1;
                    w_in_ready_nxt  = 1'b1;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_in_ready_nxt = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset aborts any multiply in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out       <= w_out_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_seq_alu_hs.sv
// Bench for seq_alu_hs: WIDTH=4 and WIDTH=8 instances, scoreboard queues
// filled on accept and drained by per-instance output monitors.
module tb_seq_alu_hs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4, v4, rdy4, ov4;
    logic [3:0]  a4, b4;
    logic [2:0]  m4;
    logic [7:0]  out4;

    logic        rst8, v8, rdy8, ov8;
    logic [7:0]  a8, b8;
    logic [2:0]  m8;
    logic [15:0] out8;

    int n_vec   = 0;
    int n_bad   = 0;
    int pulses4 = 0;

    logic [7:0]  q4[$];
    logic [15:0] q8[$];

    seq_alu_hs #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .in_valid(v4), .in_ready(rdy4),
        .A(a4), .B(b4), .MODE(m4), .out_valid(ov4), .OUT(out4)
    );

    seq_alu_hs #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .in_valid(v8), .in_ready(rdy8),
        .A(a8), .B(b8), .MODE(m8), .out_valid(ov8), .OUT(out8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model4(input logic [2:0] m, input logic [3:0] a, input logic [3:0] b);
        logic [7:0] x;
        logic [7:0] y;
        x = {4'h0, a};
        y = {4'h0, b};
        case (m)
            3'd0:    return x + y;
            3'd1:    return x & y;
            3'd2:    return (a > b) ? 8'd1 : 8'd0;
            3'd3:    return (b >= 4'd4) ? 8'd0 : (x >> b);
            3'd4:    return x - y;
            3'd5:    return x | y;
            3'd6:    return x ^ y;
            default: return x * y;
        endcase
    endfunction

    // Present operands until accepted; optionally queue the expected result
    task automatic send4(input logic [2:0] m, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] e, input bit exp_res);
        int n;
        v4 = 1'b1; m4 = m; a4 = a; b4 = b;
        n = 0;
        while (rdy4 !== 1'b1 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        if (rdy4 !== 1'b1) begin
            n_vec++; n_bad++;
            $display("FAIL w4 accept timeout: in_ready=%b, required 1", rdy4);
        end else begin
            if (exp_res) q4.push_back(e);
            @(posedge clk); #1;
        end
    endtask

    task automatic send8(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] e);
        int n;
        v8 = 1'b1; m8 = m; a8 = a; b8 = b;
        n = 0;
        while (rdy8 !== 1'b1 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        if (rdy8 !== 1'b1) begin
            n_vec++; n_bad++;
            $display("FAIL w8 accept timeout: in_ready=%b, required 1", rdy8);
        end else begin
            q8.push_back(e);
            @(posedge clk); #1;
        end
    endtask

    // Monitor for the WIDTH=4 instance
    initial begin
        forever begin
            @(negedge clk);
            if (ov4 === 1'b1) begin
                pulses4++;
                if (q4.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL w4 spurious out_valid: OUT=0x%0h, no result pending", out4);
                end else begin
                    check("w4 result", 32'(out4), 32'(q4.pop_front()));
                end
            end
        end
    end

    // Monitor for the WIDTH=8 instance
    initial begin
        forever begin
            @(negedge clk);
            if (ov8 === 1'b1) begin
                if (q8.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL w8 spurious out_valid: OUT=0x%0h, no result pending", out8);
                end else begin
                    check("w8 result", 32'(out8), 32'(q8.pop_front()));
                end
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        int n;
        rst4 = 1'b1; rst8 = 1'b1;
        v4 = 1'b0; a4 = '0; b4 = '0; m4 = '0;
        v8 = 1'b0; a8 = '0; b8 = '0; m8 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("w4 reset OUT", 32'(out4), 32'd0);
        check("w4 reset out_valid", 32'(ov4), 32'd0);
        check("w4 reset in_ready", 32'(rdy4), 32'd1);
        check("w8 reset OUT", 32'(out8), 32'd0);
        check("w8 reset out_valid", 32'(ov8), 32'd0);
        check("w8 reset in_ready", 32'(rdy8), 32'd1);
        @(negedge clk);
        rst4 = 1'b0; rst8 = 1'b0;
        @(posedge clk); #1;

        // Back-to-back single-cycle ops: one result per cycle
        send4(3'd0, 4'd15, 4'd15, 8'd30, 1'b1);
        @(negedge clk); check("b2b out_valid 1", 32'(ov4), 32'd1);
        send4(3'd4, 4'd3, 4'd5, 8'hFE, 1'b1);
        @(negedge clk); check("b2b out_valid 2", 32'(ov4), 32'd1);
        send4(3'd2, 4'd5, 4'd3, 8'd1, 1'b1);
        @(negedge clk); check("b2b out_valid 3", 32'(ov4), 32'd1);
        send4(3'd2, 4'd3, 4'd3, 8'd0, 1'b1);
        @(negedge clk); check("b2b out_valid 4", 32'(ov4), 32'd1);
        send4(3'd3, 4'd8, 4'd9, 8'd0, 1'b1);
        @(negedge clk); check("b2b out_valid 5", 32'(ov4), 32'd1);
        v4 = 1'b0;
        @(negedge clk); check("b2b out_valid drop", 32'(ov4), 32'd0);

        // MUL 15x15 with an ADD held during busy
        send4(3'd0, 4'd2, 4'd3, 8'd5, 1'b1);
        send4(3'd7, 4'd15, 4'd15, 8'd225, 1'b1);
        v4 = 1'b1; m4 = 3'd0; a4 = 4'd1; b4 = 4'd1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("mul busy in_ready", 32'(rdy4), 32'd0);
            check("mul busy out_valid", 32'(ov4), 32'd0);
            check("mul busy OUT held", 32'(out4), 32'd5);
        end
        @(posedge clk); #1;
        check("mul done in_ready", 32'(rdy4), 32'd1);
        check("mul done out_valid", 32'(ov4), 32'd1);
        send4(3'd0, 4'd1, 4'd1, 8'd2, 1'b1);
        v4 = 1'b0;
        @(negedge clk);

        // Reset two cycles into a multiply
        send4(3'd7, 4'd7, 4'd9, 8'd0, 1'b0);
        v4 = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst4 = 1'b1;
        #1;
        check("abort OUT", 32'(out4), 32'd0);
        check("abort out_valid", 32'(ov4), 32'd0);
        check("abort in_ready", 32'(rdy4), 32'd1);
        @(negedge clk);
        rst4 = 1'b0;
        send4(3'd0, 4'd2, 4'd2, 8'd4, 1'b1);
        v4 = 1'b0;
        @(negedge clk);

        // Idle handshake: nothing moves
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle out_valid", 32'(ov4), 32'd0);
            check("idle OUT", 32'(out4), 32'd4);
            check("idle in_ready", 32'(rdy4), 32'd1);
        end

        // Exhaustive sweep at WIDTH=4
        @(posedge clk); #1;
        p0 = pulses4;
        for (int m = 0; m < 8; m++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    send4(3'(m), 4'(a), 4'(b), model4(3'(m), 4'(a), 4'(b)), 1'b1);
        v4 = 1'b0;
        n = 0;
        while (q4.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        check("sweep pulse count", 32'(pulses4 - p0), 32'd2048);
        check("sweep queue drained", 32'(q4.size()), 32'd0);

        // WIDTH=8 boundary vectors
        @(posedge clk); #1;
        send8(3'd7, 8'd255, 8'd255, 16'hFE01);
        v8 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("w8 mul busy in_ready", 32'(rdy8), 32'd0);
            check("w8 mul busy out_valid", 32'(ov8), 32'd0);
        end
        @(posedge clk); #1;
        check("w8 mul done out_valid", 32'(ov8), 32'd1);
        check("w8 mul done in_ready", 32'(rdy8), 32'd1);
        send8(3'd0, 8'd255, 8'd1, 16'h0100);
        send8(3'd4, 8'd0, 8'd1, 16'hFFFF);
        send8(3'd3, 8'h80, 8'd7, 16'h0001);
        v8 = 1'b0;
        n = 0;
        while (q8.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        check("w8 queue drained", 32'(q8.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
